// File: rtl/rsa_operand_loader.sv
// Framed UART byte loader: header-addressed operand channels with shadow staging and inter-byte timeout.
// Optional trailing XOR checksum byte enabled by defining RSA_LOADER_CSUM_EN.
module rsa_operand_loader #(
    parameter int DATA_WIDTH     = 1024,
    parameter int NUM_OPERANDS   = 3,
    parameter int MSB_FIRST      = 0,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rx_dv,
    input  logic [7:0]                       rx_byte,
    input  logic [NUM_OPERANDS-1:0]          clear_valid,
    output logic [NUM_OPERANDS*DATA_WIDTH-1:0] op_data,
    output logic [NUM_OPERANDS-1:0]          op_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [1:0]                       err_code
);
    localparam int N_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W   = $clog2(N_BYTES + 1);
    localparam int GAP_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
`ifdef RSA_LOADER_CSUM_EN
        CSUM,
`endif
        COMMIT
    } state_t;

    state_t                  state;
    logic [3:0]              idx;
    logic [CNT_W-1:0]        cnt;
    logic [GAP_W-1:0]        gap;
    logic [DATA_WIDTH-1:0]   shadow;
    logic [DATA_WIDTH-1:0]   shadow_next;
    logic [DATA_WIDTH+7:0]   shift_lsb;
    logic [DATA_WIDTH+7:0]   shift_msb;
    logic                    header_ok;
    logic                    gap_expired;
`ifdef RSA_LOADER_CSUM_EN
    logic [7:0]              csum;
`endif

    // Concatenate-then-slice keeps the shift legal even when DATA_WIDTH is 8.
    always_comb begin
        shift_lsb   = {rx_byte, shadow};
        shift_msb   = {shadow, rx_byte};
        shadow_next = (MSB_FIRST != 0) ? shift_msb[DATA_WIDTH-1:0] : shift_lsb[DATA_WIDTH+7:8];
        header_ok   = (rx_byte[7:4] == 4'hA) && (int'(rx_byte[3:0]) < NUM_OPERANDS);
        gap_expired = (gap == GAP_W'(TIMEOUT_CYCLES - 1));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            gap      <= '0;
            shadow   <= '0;
            op_data  <= '0;
            op_valid <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
`ifdef RSA_LOADER_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            op_valid <= op_valid & ~clear_valid;
            case (state)
                IDLE: begin
                    gap <= '0;
                    if (rx_dv) begin
                        if (header_ok) begin
                            idx    <= rx_byte[3:0];
                            cnt    <= '0;
                            shadow <= '0;
`ifdef RSA_LOADER_CSUM_EN
                            csum   <= rx_byte;
`endif
                            state  <= DATA;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end
                    end
                end
                DATA: begin
                    if (rx_dv) begin
                        shadow <= shadow_next;
                        cnt    <= cnt + 1'b1;
                        gap    <= '0;
`ifdef RSA_LOADER_CSUM_EN
                        csum   <= csum ^ rx_byte;
                        if (cnt == CNT_W'(N_BYTES - 1)) state <= CSUM;
`else
                        if (cnt == CNT_W'(N_BYTES - 1)) state <= COMMIT;
`endif
                    end else if (gap_expired) begin
                        err      <= 1'b1;
                        err_code <= 2'b10;
                        state    <= IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
`ifdef RSA_LOADER_CSUM_EN
                CSUM: begin
                    if (rx_dv) begin
                        gap <= '0;
                        if (rx_byte == csum) begin
                            state <= COMMIT;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                            state    <= IDLE;
                        end
                    end else if (gap_expired) begin
                        err      <= 1'b1;
                        err_code <= 2'b10;
                        state    <= IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
`endif
                COMMIT: begin
                    // Later assignment overrides the clear above, so a same-cycle commit wins.
                    for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
                        if (idx == 4'(i)) begin
                            op_data[i*DATA_WIDTH +: DATA_WIDTH] <= shadow;
                            op_valid[i]                         <= 1'b1;
                        end
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench for rsa_operand_loader: LSB-first and MSB-first instances share one byte stream.
module tb_rsa_operand_loader;
    localparam int DW = 32;
    localparam int NO = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [NO-1:0] clear_valid;

    logic [NO*DW-1:0] data0, data1;
    logic [NO-1:0]    valid0, valid1;
    logic             busy0, busy1, done0, done1, err0, err1;
    logic [1:0]       code0, code1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rsa_operand_loader #(.DATA_WIDTH(DW), .NUM_OPERANDS(NO), .MSB_FIRST(0), .TIMEOUT_CYCLES(1000)) u_lsb (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte), .clear_valid(clear_valid),
        .op_data(data0), .op_valid(valid0), .busy(busy0), .done(done0), .err(err0), .err_code(code0)
    );

    rsa_operand_loader #(.DATA_WIDTH(DW), .NUM_OPERANDS(NO), .MSB_FIRST(1), .TIMEOUT_CYCLES(1000)) u_msb (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte), .clear_valid(clear_valid),
        .op_data(data1), .op_valid(valid1), .busy(busy1), .done(done1), .err(err1), .err_code(code1)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte sampled on the posedge between the two negedges; returns just after that edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
        send_byte(hdr);
        send_byte(d0);
        send_byte(d1);
        send_byte(d2);
        send_byte(d3);
`ifdef RSA_LOADER_CSUM_EN
        send_byte(hdr ^ d0 ^ d1 ^ d2 ^ d3);
`endif
    endtask

    initial begin
        reset       = 1'b1;
        rx_dv       = 1'b0;
        rx_byte     = 8'h00;
        clear_valid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst op_data", data0, 96'h0);
        check("rst op_valid", valid0, 3'b000);
        check("rst busy", busy0, 1'b0);
        check("rst done", done0, 1'b0);
        check("rst err", err0, 1'b0);
        check("rst err_code", code0, 2'b00);

        // Basic frame to channel 1
        send_byte(8'hA1);
        check("busy after header", busy0, 1'b1);
        send_byte(8'hEF);
        send_byte(8'hDE);
        send_byte(8'hBC);
        send_byte(8'hAB);
`ifdef RSA_LOADER_CSUM_EN
        send_byte(8'h87);
`endif
        check("done before commit", done0, 1'b0);
        check("busy in commit", busy0, 1'b1);
        @(negedge clk);
        check("done pulse", done0, 1'b1);
        check("ch1 lsb-first", data0[63:32], 32'hABBCDEEF);
        check("ch1 msb-first", data1[63:32], 32'hEFDEBCAB);
        check("valid after ch1", valid0, 3'b010);
        check("ch0 untouched", data0[31:0], 32'h0);
        @(negedge clk);
        check("done one cycle", done0, 1'b0);
        check("busy idle", busy0, 1'b0);

`ifdef RSA_LOADER_CSUM_EN
        // Bad checksum: frame is dropped
        send_byte(8'hA1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h00);
        check("csum err", err0, 1'b1);
        check("csum err_code", code0, 2'b11);
        check("csum busy", busy0, 1'b0);
        check("csum valid kept", valid0, 3'b010);
        check("csum data kept", data0[63:32], 32'hABBCDEEF);
        @(negedge clk);
        check("csum err one cycle", err0, 1'b0);
        check("csum no done", done0, 1'b0);
`endif

        // Bad header then a good frame to channel 2
        send_byte(8'hA5);
        check("hdr err", err0, 1'b1);
        check("hdr err_code", code0, 2'b01);
        check("hdr busy", busy0, 1'b0);
        @(negedge clk);
        check("hdr err one cycle", err0, 1'b0);
        send_frame(8'hA2, 8'h01, 8'h02, 8'h03, 8'h04);
        @(negedge clk);
        check("ch2 done", done0, 1'b1);
        check("ch2 lsb-first", data0[95:64], 32'h04030201);
        check("ch2 msb-first", data1[95:64], 32'h01020304);
        check("valid after ch2", valid0, 3'b110);
        check("ch1 retained", data0[63:32], 32'hABBCDEEF);

        // Timeout inside a frame
        send_byte(8'hA0);
        send_byte(8'h11);
        send_byte(8'h22);
        check("to busy", busy0, 1'b1);
        repeat (999) @(negedge clk);
        check("to not early", err0, 1'b0);
        check("to still busy", busy0, 1'b1);
        @(negedge clk);
        check("to err", err0, 1'b1);
        check("to err msb", err1, 1'b1);
        check("to err_code", code0, 2'b10);
        check("to busy low", busy0, 1'b0);
        check("to valid kept", valid0, 3'b110);
        send_frame(8'hA0, 8'h01, 8'h02, 8'h03, 8'h04);
        @(negedge clk);
        check("ch0 done", done0, 1'b1);
        check("ch0 lsb-first", data0[31:0], 32'h04030201);
        check("ch0 msb-first", data1[31:0], 32'h01020304);
        check("valid all", valid0, 3'b111);
        check("err_code holds", code0, 2'b10);

        // Plain clear keeps data
        @(negedge clk);
        clear_valid = 3'b100;
        @(negedge clk);
        clear_valid = '0;
        check("clear ch2 valid", valid0, 3'b011);
        check("clear ch2 data", data0[95:64], 32'h04030201);

        // Commit and clear on channel 1 in the same cycle
        send_frame(8'hA1, 8'h11, 8'h22, 8'h33, 8'h44);
        clear_valid = 3'b010;
        @(negedge clk);
        clear_valid = '0;
        check("race done", done0, 1'b1);
        check("race valid", valid0, 3'b011);
        check("race ch1 lsb", data0[63:32], 32'h44332211);
        check("race ch1 msb", data1[63:32], 32'h11223344);

        // Reset mid-frame wipes everything
        send_byte(8'hA1);
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid rst op_data", data0, 96'h0);
        check("mid rst op_data msb", data1, 96'h0);
        check("mid rst op_valid", valid0, 3'b000);
        check("mid rst busy", busy0, 1'b0);
        check("mid rst done", done0, 1'b0);
        check("mid rst err", err0, 1'b0);
        check("mid rst err_code", code0, 2'b00);

        send_frame(8'hA2, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
        @(negedge clk);
        check("post rst ch2", data0[95:64], 32'hEFBEADDE);
        check("post rst valid", valid0, 3'b100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
